// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 character LCD driver.
// Holds the state enums, the power-on command list and the byte translation.
package lcd_pkg;

    typedef enum logic [1:0] {
        ST_POWERUP,
        ST_INIT_CMD,
        ST_IDLE,
        ST_WRITE
    } state_e;

    typedef enum logic [2:0] {
        PH_IDLE,
        PH_SETUP,
        PH_PULSE,
        PH_HOLD,
        PH_WAIT
    } phase_e;

    localparam logic [7:0] LCD_CMD_FUNC    = 8'h38;
    localparam logic [7:0] LCD_CMD_DISP_ON = 8'h0C;
    localparam logic [7:0] LCD_CMD_CLEAR   = 8'h01;
    localparam logic [7:0] LCD_CMD_ENTRY   = 8'h06;
    localparam logic [7:0] LCD_CMD_LINE2   = 8'hC0;
    localparam logic [7:0] CHAR_NL         = 8'h0A;
    localparam logic [7:0] CHAR_FF         = 8'h0C;

    typedef struct packed {
        logic [7:0] cmd;
        logic       longWait;
    } init_cmd_t;

    typedef struct packed {
        logic [7:0] data;
        logic       rs;
        logic       longWait;
    } strobe_req_t;

    localparam int INIT_LEN = 5;

    // Only the clear command needs the long post-strobe wait.
    localparam init_cmd_t INIT_SEQ [INIT_LEN] = '{
        '{cmd: LCD_CMD_FUNC,    longWait: 1'b0},
        '{cmd: LCD_CMD_FUNC,    longWait: 1'b0},
        '{cmd: LCD_CMD_DISP_ON, longWait: 1'b0},
        '{cmd: LCD_CMD_CLEAR,   longWait: 1'b1},
        '{cmd: LCD_CMD_ENTRY,   longWait: 1'b0}
    };

    function automatic strobe_req_t initRequest(input logic [2:0] idx);
        strobe_req_t req;
        req.data     = INIT_SEQ[idx].cmd;
        req.rs       = 1'b0;
        req.longWait = INIT_SEQ[idx].longWait;
        return req;
    endfunction

    // Newline moves to line 2, form feed clears; everything else is printed.
    function automatic strobe_req_t translateByte(input logic [7:0] b);
        strobe_req_t req;
        if (b == CHAR_NL) begin
            req.data     = LCD_CMD_LINE2;
            req.rs       = 1'b0;
            req.longWait = 1'b0;
        end else if (b == CHAR_FF) begin
            req.data     = LCD_CMD_CLEAR;
            req.rs       = 1'b0;
            req.longWait = 1'b1;
        end else begin
            req.data     = b;
            req.rs       = 1'b1;
            req.longWait = 1'b0;
        end
        return req;
    endfunction

endpackage

// File: rtl/lcd_strobe.sv
// Generates one LCD bus write: setup, enable pulse, hold and execution wait.
// o_done is combinational so the caller can react on the same edge the write ends.
module lcd_strobe
    import lcd_pkg::*;
#(
    parameter int SETUP_CYCLES = 2,
    parameter int PULSE_CYCLES = 12,
    parameter int HOLD_CYCLES  = 2,
    parameter int EXEC_CYCLES  = 2500,
    parameter int CLEAR_CYCLES = 82000
) (
    input  logic       clock,
    input  logic       internal_reset,
    input  logic       i_start,
    input  logic       i_rs,
    input  logic [7:0] i_byte,
    input  logic       i_longWait,
    output logic       o_lcdE,
    output logic       o_lcdRs,
    output logic [7:0] o_lcdData,
    output logic       o_done
);

    localparam int MAX_SP  = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
    localparam int MAX_HE  = (HOLD_CYCLES > EXEC_CYCLES) ? HOLD_CYCLES : EXEC_CYCLES;
    localparam int MAX_SPH = (MAX_SP > MAX_HE) ? MAX_SP : MAX_HE;
    localparam int MAX_ALL = (MAX_SPH > CLEAR_CYCLES) ? MAX_SPH : CLEAR_CYCLES;
    localparam int CW      = $clog2(MAX_ALL) + 1;

    phase_e          r_phase;
    logic [CW-1:0]   r_count;
    logic            r_longWait;
    logic            r_rs;
    logic [7:0]      r_data;
    logic            r_e;

    phase_e          w_nextPhase;
    logic [CW-1:0]   w_nextCount;
    logic            w_last;
    logic            w_accept;
    logic            w_reload;

    function automatic int phaseLen(input phase_e p, input logic lw);
        int len;
        case (p)
            PH_SETUP: len = SETUP_CYCLES;
            PH_PULSE: len = PULSE_CYCLES;
            PH_HOLD:  len = HOLD_CYCLES;
            PH_WAIT:  len = lw ? CLEAR_CYCLES : EXEC_CYCLES;
            default:  len = 0;
        endcase
        return len;
    endfunction

    // Zero-length phases are skipped by looking ahead to the next non-empty one.
    function automatic phase_e phaseAfter(input phase_e p, input logic lw);
        phase_e n;
        n = PH_IDLE;
        case (p)
            PH_IDLE:  n = (SETUP_CYCLES > 0) ? PH_SETUP : PH_PULSE;
            PH_SETUP: n = PH_PULSE;
            PH_PULSE: n = (HOLD_CYCLES > 0) ? PH_HOLD :
                          ((phaseLen(PH_WAIT, lw) > 0) ? PH_WAIT : PH_IDLE);
            PH_HOLD:  n = (phaseLen(PH_WAIT, lw) > 0) ? PH_WAIT : PH_IDLE;
            default:  n = PH_IDLE;
        endcase
        return n;
    endfunction

    function automatic logic [CW-1:0] phaseLoad(input phase_e p, input logic lw);
        int len;
        len = phaseLen(p, lw);
        return (len > 0) ? CW'(len - 1) : '0;
    endfunction

    // The counter holds the cycles left in the current phase after this one.
    always_comb begin
        w_nextPhase = r_phase;
        w_nextCount = r_count;
        w_accept    = 1'b0;
        w_reload    = 1'b0;
        o_done      = 1'b0;
        w_last      = (r_phase != PH_IDLE) && (r_count == '0);
        if (w_last) begin
            w_nextPhase = phaseAfter(r_phase, r_longWait);
            o_done      = (w_nextPhase == PH_IDLE);
            w_reload    = 1'b1;
        end else if (r_phase != PH_IDLE) begin
            w_nextCount = r_count - CW'(1);
        end
        if (i_start && ((r_phase == PH_IDLE) || o_done)) begin
            w_accept    = 1'b1;
            w_nextPhase = phaseAfter(PH_IDLE, i_longWait);
            w_reload    = 1'b1;
        end
        if (w_reload) begin
            w_nextCount = phaseLoad(w_nextPhase, w_accept ? i_longWait : r_longWait);
        end
    end

    always_ff @(posedge clock) begin
        if (internal_reset) begin
            r_phase    <= PH_IDLE;
            r_count    <= '0;
            r_longWait <= 1'b0;
            r_rs       <= 1'b0;
            r_data     <= 8'h00;
            r_e        <= 1'b0;
        end else begin
            r_phase <= w_nextPhase;
            r_count <= w_nextCount;
            r_e     <= (w_nextPhase == PH_PULSE);
            if (w_accept) begin
                r_rs       <= i_rs;
                r_data     <= i_byte;
                r_longWait <= i_longWait;
            end
        end
    end

    assign o_lcdE    = r_e;
    assign o_lcdRs   = r_rs;
    assign o_lcdData = r_data;

endmodule

// File: rtl/lcd_driver.sv
// HD44780 8-bit driver: power-up delay, fixed init sequence, then one byte per
// data_ready handshake while lcd_busy is low.
module lcd_driver
    import lcd_pkg::*;
#(
    parameter int POWERUP_CYCLES = 750000,
    parameter int SETUP_CYCLES   = 2,
    parameter int PULSE_CYCLES   = 12,
    parameter int HOLD_CYCLES    = 2,
    parameter int EXEC_CYCLES    = 2500,
    parameter int CLEAR_CYCLES   = 82000
) (
    input  logic       clock,
    input  logic       internal_reset,
    input  logic       data_ready,
    input  logic [7:0] data_in,
    output logic       lcd_busy,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e
);

    localparam int             PW       = $clog2(POWERUP_CYCLES + 1) + 1;
    localparam logic [PW-1:0]  PWR_LAST = (POWERUP_CYCLES > 0) ? PW'(POWERUP_CYCLES - 1) : '0;
    localparam logic [2:0]     LAST_IDX = 3'(INIT_LEN - 1);

    state_e         r_state;
    logic [PW-1:0]  r_pwrCount;
    logic [2:0]     r_initIdx;
    logic           r_busy;

    state_e         w_nextState;
    logic [PW-1:0]  w_pwrNext;
    logic [2:0]     w_nextIdx;
    logic           w_nextBusy;
    logic           w_start;
    strobe_req_t    w_req;
    logic           w_strobeDone;

    // Each new strobe is launched on the edge the previous one finishes,
    // so init commands run back to back with no idle gap.
    always_comb begin
        w_nextState = r_state;
        w_pwrNext   = r_pwrCount;
        w_nextIdx   = r_initIdx;
        w_nextBusy  = r_busy;
        w_start     = 1'b0;
        w_req       = '0;
        case (r_state)
            ST_POWERUP: begin
                if (r_pwrCount == PWR_LAST) begin
                    w_start     = 1'b1;
                    w_req       = initRequest(3'd0);
                    w_nextIdx   = 3'd0;
                    w_nextState = ST_INIT_CMD;
                end else begin
                    w_pwrNext = r_pwrCount + PW'(1);
                end
            end
            ST_INIT_CMD: begin
                if (w_strobeDone) begin
                    if (r_initIdx == LAST_IDX) begin
                        w_nextState = ST_IDLE;
                        w_nextBusy  = 1'b0;
                    end else begin
                        w_start   = 1'b1;
                        w_req     = initRequest(r_initIdx + 3'd1);
                        w_nextIdx = r_initIdx + 3'd1;
                    end
                end
            end
            ST_IDLE: begin
                if (data_ready) begin
                    w_start     = 1'b1;
                    w_req       = translateByte(data_in);
                    w_nextBusy  = 1'b1;
                    w_nextState = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (w_strobeDone) begin
                    w_nextState = ST_IDLE;
                    w_nextBusy  = 1'b0;
                end
            end
            default: begin
                w_nextState = ST_POWERUP;
                w_nextBusy  = 1'b1;
            end
        endcase
    end

    // Busy comes out of reset high so the controller never sees a free LCD early.
    always_ff @(posedge clock) begin
        if (internal_reset) begin
            r_state    <= ST_POWERUP;
            r_pwrCount <= '0;
            r_initIdx  <= 3'd0;
            r_busy     <= 1'b1;
        end else begin
            r_state    <= w_nextState;
            r_pwrCount <= w_pwrNext;
            r_initIdx  <= w_nextIdx;
            r_busy     <= w_nextBusy;
        end
    end

    lcd_strobe #(
        .SETUP_CYCLES (SETUP_CYCLES),
        .PULSE_CYCLES (PULSE_CYCLES),
        .HOLD_CYCLES  (HOLD_CYCLES),
        .EXEC_CYCLES  (EXEC_CYCLES),
        .CLEAR_CYCLES (CLEAR_CYCLES)
    ) u_strobe (
        .clock          (clock),
        .internal_reset (internal_reset),
        .i_start        (w_start),
        .i_rs           (w_req.rs),
        .i_byte         (w_req.data),
        .i_longWait     (w_req.longWait),
        .o_lcdE         (lcd_e),
        .o_lcdRs        (lcd_rs),
        .o_lcdData      (lcd_data),
        .o_done         (w_strobeDone)
    );

    assign lcd_busy = r_busy;
    assign lcd_rw   = 1'b0;

endmodule

// File: tb/tb_lcd_driver.sv
// Bench for lcd_driver: a scoreboard of expected bus writes is checked at every
// E pulse, while table-driven writes check the busy window of each byte.
module tb_lcd_driver;

    logic       clock = 1'b0;
    logic       internal_reset;
    logic       data_ready;
    logic [7:0] data_in;
    logic       lcd_busy;
    logic [7:0] lcd_data;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;

    lcd_driver #(
        .POWERUP_CYCLES (20),
        .SETUP_CYCLES   (2),
        .PULSE_CYCLES   (3),
        .HOLD_CYCLES    (2),
        .EXEC_CYCLES    (5),
        .CLEAR_CYCLES   (10)
    ) dut (
        .clock          (clock),
        .internal_reset (internal_reset),
        .data_ready     (data_ready),
        .data_in        (data_in),
        .lcd_busy       (lcd_busy),
        .lcd_data       (lcd_data),
        .lcd_rs         (lcd_rs),
        .lcd_rw         (lcd_rw),
        .lcd_e          (lcd_e)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] data;
        logic       rs;
    } exp_t;

    typedef struct {
        logic [7:0] dataIn;
        logic [7:0] expData;
        logic       expRs;
        int         expBusy;
        bit         poke;
    } vec_t;

    exp_t       scoreQ[$];
    int         nChecks = 0;
    int         nFails  = 0;
    int         pulseCount = 0;
    bit         saw55 = 1'b0;
    logic       prevE = 1'b0;
    bit         inPulse = 1'b0;
    int         width = 0;
    logic [7:0] pulseData;
    logic       pulseRs;
    vec_t       vecs[7];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic pushInit();
        scoreQ.push_back('{8'h38, 1'b0});
        scoreQ.push_back('{8'h38, 1'b0});
        scoreQ.push_back('{8'h0C, 1'b0});
        scoreQ.push_back('{8'h01, 1'b0});
        scoreQ.push_back('{8'h06, 1'b0});
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    always @(posedge clock) begin
        #1;
        if (lcd_data == 8'h55) saw55 = 1'b1;
        if (internal_reset) begin
            inPulse = 1'b0;
            prevE   = 1'b0;
        end else begin
            if (lcd_e && !prevE) begin
                pulseCount++;
                checkOutput("scoreboard has entry at E rise", 32'(scoreQ.size() > 0), 32'd1);
                if (scoreQ.size() > 0) begin
                    exp_t e;
                    e = scoreQ.pop_front();
                    checkOutput("lcd_data at E rise", 32'(lcd_data), 32'(e.data));
                    checkOutput("lcd_rs at E rise", 32'(lcd_rs), 32'(e.rs));
                end
                pulseData = lcd_data;
                pulseRs   = lcd_rs;
                inPulse   = 1'b1;
                width     = 1;
            end else if (lcd_e && inPulse) begin
                width++;
            end else if (!lcd_e && prevE && inPulse) begin
                checkOutput("E pulse width", 32'(width), 32'd3);
                checkOutput("lcd_data held after E fall", 32'(lcd_data), 32'(pulseData));
                checkOutput("lcd_rs held after E fall", 32'(lcd_rs), 32'(pulseRs));
                inPulse = 1'b0;
            end
            prevE = lcd_e;
        end
    end

    task automatic waitIdle();
        int cnt = 0;
        while (lcd_busy && cnt < 400) begin
            @(negedge clock);
            cnt++;
        end
        if (lcd_busy) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL waitIdle timeout: lcd_busy still 1 after %0d cycles", cnt);
        end
    endtask

    task automatic waitInit(input bit poke);
        int cnt = 0;
        while (lcd_busy && cnt < 1000) begin
            @(negedge clock);
            cnt++;
            if (poke && cnt == 30) begin
                data_ready = 1'b1;
                data_in    = 8'h55;
            end
            if (poke && cnt == 31) begin
                data_ready = 1'b0;
                data_in    = 8'h00;
            end
        end
        checkOutput("busy fell after init", 32'(lcd_busy), 32'd0);
        checkOutput("E pulses before busy fell", 32'(pulseCount), 32'd5);
    endtask

    task automatic applyStimulus(input vec_t v);
        int cnt = 0;
        waitIdle();
        data_ready = 1'b1;
        data_in    = v.dataIn;
        scoreQ.push_back('{v.expData, v.expRs});
        @(negedge clock);
        data_ready = 1'b0;
        data_in    = ~v.dataIn;
        checkOutput("busy after accept", 32'(lcd_busy), 32'd1);
        checkOutput("lcd_data after accept", 32'(lcd_data), 32'(v.expData));
        checkOutput("lcd_rs after accept", 32'(lcd_rs), 32'(v.expRs));
        while (lcd_busy && cnt < 100) begin
            @(negedge clock);
            cnt++;
            if (v.poke && cnt == 4) begin
                data_ready = 1'b1;
                data_in    = 8'h55;
            end
            if (v.poke && cnt == 6) begin
                data_ready = 1'b0;
                data_in    = 8'h00;
            end
        end
        checkOutput("busy window cycles", 32'(cnt), 32'(v.expBusy));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        string msg;
        int    cnt;
        int    startPulses;
        vec_t  v;

        vecs[0] = '{8'h48, 8'h48, 1'b1, 12, 1'b0};
        vecs[1] = '{8'h0A, 8'hC0, 1'b0, 12, 1'b0};
        vecs[2] = '{8'h0C, 8'h01, 1'b0, 17, 1'b0};
        vecs[3] = '{8'h41, 8'h41, 1'b1, 12, 1'b1};
        vecs[4] = '{8'h0B, 8'h0B, 1'b1, 12, 1'b0};
        vecs[5] = '{8'h00, 8'h00, 1'b1, 12, 1'b0};
        vecs[6] = '{8'hFF, 8'hFF, 1'b1, 12, 1'b0};

        internal_reset = 1'b1;
        data_ready     = 1'b0;
        data_in        = 8'h00;
        pushInit();
        @(negedge clock);
        checkOutput("reset lcd_busy", 32'(lcd_busy), 32'd1);
        checkOutput("reset lcd_e", 32'(lcd_e), 32'd0);
        checkOutput("reset lcd_rs", 32'(lcd_rs), 32'd0);
        checkOutput("reset lcd_rw", 32'(lcd_rw), 32'd0);
        checkOutput("reset lcd_data", 32'(lcd_data), 32'd0);
        repeat (2) @(negedge clock);
        internal_reset = 1'b0;
        pulseCount     = 0;
        @(negedge clock);
        checkOutput("busy right after reset release", 32'(lcd_busy), 32'd1);
        waitInit(1'b1);

        for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

        // Held data_ready: second byte is taken in the very first idle cycle.
        waitIdle();
        data_ready = 1'b1;
        data_in    = 8'h42;
        scoreQ.push_back('{8'h42, 1'b1});
        @(negedge clock);
        data_in = 8'h5A;
        cnt = 0;
        while (lcd_busy && cnt < 100) begin
            @(negedge clock);
            cnt++;
        end
        checkOutput("first byte busy window", 32'(cnt), 32'd12);
        scoreQ.push_back('{8'h5A, 1'b1});
        @(negedge clock);
        data_ready = 1'b0;
        checkOutput("accepted in first idle cycle", 32'(lcd_busy), 32'd1);
        checkOutput("second byte on bus", 32'(lcd_data), 32'h5A);
        cnt = 0;
        while (lcd_busy && cnt < 100) begin
            @(negedge clock);
            cnt++;
        end
        checkOutput("second byte busy window", 32'(cnt), 32'd12);

        // Reset in the middle of the enable pulse.
        waitIdle();
        data_ready = 1'b1;
        data_in    = 8'h52;
        scoreQ.push_back('{8'h52, 1'b1});
        @(negedge clock);
        data_ready = 1'b0;
        cnt = 0;
        while (!lcd_e && cnt < 20) begin
            @(negedge clock);
            cnt++;
        end
        checkOutput("E rose before mid-pulse reset", 32'(lcd_e), 32'd1);
        @(negedge clock);
        internal_reset = 1'b1;
        scoreQ.delete();
        pushInit();
        @(negedge clock);
        checkOutput("E low after mid-pulse reset", 32'(lcd_e), 32'd0);
        checkOutput("busy after mid-pulse reset", 32'(lcd_busy), 32'd1);
        internal_reset = 1'b0;
        pulseCount     = 0;
        waitInit(1'b0);

        // Controller-style run over a short ROM string.
        msg = "HELLO, WORLD!12";
        startPulses = pulseCount;
        for (int i = 0; i < msg.len(); i++) begin
            v.dataIn  = msg[i];
            v.expData = msg[i];
            v.expRs   = 1'b1;
            v.expBusy = 12;
            v.poke    = 1'b0;
            applyStimulus(v);
        end
        repeat (5) @(negedge clock);
        checkOutput("one E pulse per ROM character", 32'(pulseCount - startPulses), 32'd15);

        repeat (20) @(negedge clock);
        checkOutput("scoreboard drained", 32'(scoreQ.size()), 32'd0);
        checkOutput("0x55 never on lcd_data", 32'(saw55), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
